// File: rtl/processor_control_unit.sv
// Per-lane worker: accepts a (row, col) pair from main_CU, walks row of A and column of B
// over the arbitrated memory bus, accumulates the dot product and writes C[row][col] back.
module processor_control_unit #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int IW = 8
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Indexes_Ready,
    input  logic [IW-1:0] i_Row_Index,
    input  logic [IW-1:0] i_Column_Index,
    output logic          o_Indexes_Received,
    input  logic [IW-1:0] i_Dimension,
    input  logic [AW-1:0] i_A_Base,
    input  logic [AW-1:0] i_B_Base,
    input  logic [AW-1:0] i_C_Base,
    output logic          o_Grant_Request,
    input  logic          i_Grant,
    output logic [AW-1:0] o_Memory_Address,
    output logic          o_Memory_Read_Enable,
    output logic          o_Memory_Write_Enable,
    output logic [DW-1:0] o_Memory_Write_Data,
    input  logic [DW-1:0] i_Memory_Read_Data,
    output logic          o_Result_Ready,
    output logic          o_Busy
);

    typedef enum logic [2:0] {
        IDLE, ACK, REQUEST, READ_A, READ_B, ACCUM, WRITE, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   dim_q, dim_d;
    logic [IW-1:0]   k_q, k_d;
    logic [AW-1:0]   a_ptr_q, a_ptr_d;
    logic [AW-1:0]   b_ptr_q, b_ptr_d;
    logic [AW-1:0]   c_addr_q, c_addr_d;
    logic [DW-1:0]   r_a_q, r_a_d;
    logic [2*DW-1:0] acc_q, acc_d;

    logic [AW-1:0]   row_off;
    logic [IW-1:0]   k_next;
    logic [2*DW-1:0] product;

    assign row_off = AW'(i_Row_Index) * AW'(i_Dimension);
    assign k_next  = k_q + IW'(1);
    assign product = (2*DW)'(r_a_q) * (2*DW)'(i_Memory_Read_Data);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d               = state_q;
        dim_d                 = dim_q;
        k_d                   = k_q;
        a_ptr_d               = a_ptr_q;
        b_ptr_d               = b_ptr_q;
        c_addr_d              = c_addr_q;
        r_a_d                 = r_a_q;
        acc_d                 = acc_q;
        o_Indexes_Received    = 1'b0;
        o_Grant_Request       = 1'b0;
        o_Memory_Address      = '0;
        o_Memory_Read_Enable  = 1'b0;
        o_Memory_Write_Enable = 1'b0;
        o_Memory_Write_Data   = '0;
        o_Result_Ready        = 1'b0;
        o_Busy                = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (i_Indexes_Ready) begin
                    dim_d    = i_Dimension;
                    a_ptr_d  = i_A_Base + row_off;
                    b_ptr_d  = i_B_Base + AW'(i_Column_Index);
                    c_addr_d = i_C_Base + row_off + AW'(i_Column_Index);
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = ACK;
                end
            end
            ACK: begin
                o_Indexes_Received = 1'b1;
                state_d            = REQUEST;
            end
            REQUEST: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) state_d = (dim_q == '0) ? WRITE : READ_A;
            end
            READ_A: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    o_Memory_Address     = a_ptr_q;
                    o_Memory_Read_Enable = 1'b1;
                    state_d              = READ_B;
                end else begin
                    state_d = REQUEST;
                end
            end
            READ_B: begin
                o_Grant_Request = 1'b1;
                r_a_d           = i_Memory_Read_Data;
                if (i_Grant) begin
                    o_Memory_Address     = b_ptr_q;
                    o_Memory_Read_Enable = 1'b1;
                    state_d              = ACCUM;
                end else begin
                    // Losing the bus here discards A[k]; it is fetched again after regrant.
                    state_d = REQUEST;
                end
            end
            ACCUM: begin
                o_Grant_Request = 1'b1;
                acc_d           = acc_q + product;
                a_ptr_d         = a_ptr_q + AW'(1);
                b_ptr_d         = b_ptr_q + AW'(dim_q);
                k_d             = k_next;
                state_d         = (k_next == dim_q) ? WRITE : READ_A;
            end
            WRITE: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) begin
                    o_Memory_Address      = c_addr_q;
                    o_Memory_Write_Enable = 1'b1;
                    o_Memory_Write_Data   = acc_q[DW-1:0];
                    state_d               = DONE;
                end
            end
            DONE: begin
                o_Result_Ready = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            dim_q    <= '0;
            k_q      <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            c_addr_q <= '0;
            r_a_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            dim_q    <= dim_d;
            k_q      <= k_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            c_addr_q <= c_addr_d;
            r_a_q    <= r_a_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: doc/processor_control_unit.md
Name: processor_control_unit

Overview:
- Per-processor worker controller; one instance per processor lane, i.e. p instances beside main_CU.
- Receives a (row, column) index pair from main_CU over the Indexes_Ready / Indexes_Received handshake.
- Obtains the shared memory bus through the grant arbiter, computes C[row][col] = sum over k of A[row][k]*B[k][col], writes C back, then pulses result-ready to main_CU.

Parameters:
DW, 16, memory data width; A, B and C elements are unsigned DW bits
AW, 16, memory address width
IW, 8, width of row/column indexes and of the dimension N

Ports:
i_Clock  in  1  clock, all logic on rising edge
i_Reset  in  1  reset, synchronous, active-high
i_Indexes_Ready  in  1  this lane's bit of main_CU o_Indexes_Ready; index pair valid
i_Row_Index  in  IW  row of C to compute
i_Column_Index  in  IW  column of C to compute
o_Indexes_Received  out  1  one-cycle pulse: index pair accepted
i_Dimension  in  IW  matrix dimension N (square N x N)
i_A_Base, i_B_Base, i_C_Base  in  AW each  row-major base addresses of A, B, C
o_Grant_Request  out  1  memory bus request to arbiter
i_Grant  in  1  bus granted; address/enables valid only while high
o_Memory_Address  out  AW  memory address
o_Memory_Read_Enable  out  1  read strobe; data returns next cycle
o_Memory_Write_Enable  out  1  write strobe
o_Memory_Write_Data  out  DW  write data
i_Memory_Read_Data  in  DW  read data, valid exactly 1 cycle after a read strobe
o_Result_Ready  out  1  one-cycle pulse: C element written
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, k and pointers cleared. Reset mid-operation aborts with no write, and the next cycle shows all outputs 0.
- States: IDLE, ACK, REQUEST, READ_A, READ_B, ACCUM, WRITE, DONE.
- IDLE: when i_Indexes_Ready=1, latch row, column, i_Dimension and the three bases. Set a_ptr=A_Base+row*N, b_ptr=B_Base+col, c_addr=C_Base+row*N+col, acc=0, k=0. Go to ACK.
- ACK: o_Indexes_Received=1 for this cycle only. Go to REQUEST.
- i_Indexes_Ready is ignored outside IDLE. It is level-sampled in IDLE, so main_CU must drop it after Received.
- o_Grant_Request=1 in REQUEST, READ_A, READ_B, ACCUM and WRITE; 0 otherwise.
- REQUEST: wait for i_Grant=1. If N=0, go to WRITE; otherwise go to READ_A.
- READ_A:
  - If i_Grant=1: address=a_ptr, read_enable=1, go to READ_B.
  - If i_Grant=0: go to REQUEST.
- READ_B:
  - Always capture i_Memory_Read_Data into r_A.
  - If i_Grant=1: address=b_ptr, read_enable=1, go to ACCUM.
  - If i_Grant=0: go to REQUEST; element k is re-read from A (k unchanged).
- ACCUM:
  - acc <= acc + r_A*i_Memory_Read_Data; multiply unsigned DW x DW to 2*DW; acc is 2*DW bits and wraps modulo 2^(2*DW).
  - a_ptr+=1, b_ptr+=N, k+=1.
  - If k+1==N, go to WRITE; otherwise go to READ_A.
  - The returned data is consumed regardless of i_Grant.
- WRITE:
  - If i_Grant=1: address=c_addr, write_enable=1, write_data=acc[DW-1:0] (modulo 2^DW), go to DONE.
  - If i_Grant=0: stay in WRITE.
- DONE: o_Result_Ready=1 for one cycle, request drops. Go to IDLE.
- Strobes:
  - Read and write enables are never both high.
  - Strobes are never asserted while i_Grant=0.
  - Address is 0 when no strobe is active.
- Address arithmetic is modulo 2^AW; indexes are not range-checked.
- Latency with grant held continuously:
  - Ready sampled in cycle 0; Received in cycle 1.
  - Write in cycle 3N+3; Result_Ready in cycle 3N+4.

Test Plan:
1. Basic compute:
   - Setup: N=2; A=[[1,2],[3,4]] at 0x0000; B=[[5,6],[7,8]] at 0x0010; C_Base=0x0020; row=1, col=0; grant tied high.
   - Reads: 0x0002, 0x0010, 0x0003, 0x0012.
   - Received in cycle 1; write 43 (0x002B) to 0x0022 in cycle 9; Result_Ready in cycle 10.
2. Grant loss: as scenario 1, but i_Grant=0 for 3 cycles during READ_B at k=1 -> 0x0003 re-read after regrant; result still 43 at 0x0022; no strobe while grant is low.
3. Wrap: N=1, A[0][0]=0xFFFF, B[0][0]=0xFFFF -> write data 0x0001.
4. Zero dimension: N=0 -> no reads; write 0x0000 to C_Base+col; Result_Ready pulses.
5. Busy handshake: i_Indexes_Ready re-asserted while busy -> ignored until DONE; accepted in the following IDLE cycle with a new Received pulse.
6. Reset mid-operation: i_Reset in READ_B -> next cycle all outputs 0, state IDLE, no write ever issued.
